// File: rtl/spi_flash_arbiter.sv
// spi_flash_arbiter: round-robin, whole-transaction sharing of one SPI byte engine between two sequencers
module spi_flash_arbiter #(
    parameter int CS_HIGH_CYCLES = 4,
    parameter int HOLD_TIMEOUT = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       SPI_Start_Sig,
    output logic [8:0] SPI_Data,
    input  logic       SPI_Done_Sig,
    input  logic [7:0] SPI_Rdata,
    input  logic       C0_Req,
    output logic       C0_Grant,
    input  logic       C0_Start,
    input  logic [8:0] C0_Data,
    output logic       C0_Done,
    output logic [7:0] C0_Rdata,
    output logic       C0_Abort,
    input  logic       C1_Req,
    output logic       C1_Grant,
    input  logic       C1_Start,
    input  logic [8:0] C1_Data,
    output logic       C1_Done,
    output logic [7:0] C1_Rdata,
    output logic       C1_Abort
);
    localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, BUSY = 2'd2, GAP = 2'd3;
    logic [1:0] state;
    logic owner, last, granted, own_req, own_start, pick, done;
    logic [8:0] own_data;
    logic [15:0] hold_cnt;
    logic [7:0] gap_cnt;
    always_comb begin
        own_req = owner ? C1_Req : C0_Req;
        own_start = owner ? C1_Start : C0_Start;
        own_data = owner ? C1_Data : C0_Data;
        granted = (state == HOLD) || (state == BUSY);
        pick = (C0_Req && C1_Req) ? ~last : C1_Req;
        done = (state == BUSY) && SPI_Done_Sig;
        SPI_Start_Sig = granted && own_start;
        SPI_Data = granted ? own_data : 9'h1FF;
        C0_Grant = granted && !owner;
        C1_Grant = granted && owner;
        C0_Done = done && !owner;
        C1_Done = done && owner;
    end
    // a release with Req low is a normal handover; only a stalled requester is aborted
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            owner <= 1'b0;
            last <= 1'b1;
            hold_cnt <= '0;
            gap_cnt <= '0;
            C0_Abort <= 1'b0;
            C1_Abort <= 1'b0;
            C0_Rdata <= '0;
            C1_Rdata <= '0;
        end else begin
            C0_Abort <= 1'b0;
            C1_Abort <= 1'b0;
            case (state)
                IDLE: if (C0_Req || C1_Req) begin
                    owner <= pick;
                    last <= pick;
                    hold_cnt <= '0;
                    state <= HOLD;
                end
                HOLD: if (own_start) state <= BUSY;
                else if (!own_req || hold_cnt == 16'(HOLD_TIMEOUT - 1)) begin
                    state <= GAP;
                    gap_cnt <= '0;
                    C0_Abort <= own_req && !owner;
                    C1_Abort <= own_req && owner;
                end else if (hold_cnt != 16'hFFFF) hold_cnt <= hold_cnt + 16'd1;
                BUSY: if (SPI_Done_Sig) begin
                    state <= HOLD;
                    hold_cnt <= '0;
                    if (owner) C1_Rdata <= SPI_Rdata;
                    else C0_Rdata <= SPI_Rdata;
                end
                default: if (gap_cnt == 8'(CS_HIGH_CYCLES - 1)) state <= IDLE;
                else gap_cnt <= gap_cnt + 8'd1;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb_spi_flash_arbiter: directed scenarios plus randomized clients/engine against a behavioural bus-ownership model
module tb_spi_flash_arbiter;
    localparam int CS = 4, TO = 1024;
    logic CLK = 1'b0, RST;
    logic SPI_Start_Sig, SPI_Done_Sig;
    logic [8:0] SPI_Data;
    logic [7:0] SPI_Rdata, C0_Rdata, C1_Rdata;
    logic C0_Grant, C1_Grant, C0_Done, C1_Done, C0_Abort, C1_Abort;
    logic [1:0] req, start, grant, done, abort, sd;
    logic [1:0][8:0] data;
    logic [1:0][7:0] m_rd;
    logic [1:0] m_ab;
    logic m_busy, m_last, s_start, cli_en, noise_en, fix_en, eng_busy;
    logic [7:0] fix_val;
    int m_own, m_gap, m_idle, lat, dcnt0, k;
    int left[2];
    int checks = 0, failures = 0;
    assign grant = {C1_Grant, C0_Grant};
    assign done = {C1_Done, C0_Done};
    assign abort = {C1_Abort, C0_Abort};
    always #5 CLK = ~CLK;
    spi_flash_arbiter #(.CS_HIGH_CYCLES(CS), .HOLD_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST),
        .SPI_Start_Sig(SPI_Start_Sig), .SPI_Data(SPI_Data),
        .SPI_Done_Sig(SPI_Done_Sig), .SPI_Rdata(SPI_Rdata),
        .C0_Req(req[0]), .C0_Grant(C0_Grant), .C0_Start(start[0]), .C0_Data(data[0]),
        .C0_Done(C0_Done), .C0_Rdata(C0_Rdata), .C0_Abort(C0_Abort),
        .C1_Req(req[1]), .C1_Grant(C1_Grant), .C1_Start(start[1]), .C1_Data(data[1]),
        .C1_Done(C1_Done), .C1_Rdata(C1_Rdata), .C1_Abort(C1_Abort)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_own = -1;
        m_busy = 1'b0;
        m_gap = 0;
        m_idle = 0;
        m_last = 1'b1;
        m_rd = '0;
        m_ab = '0;
    endtask
    // ownership model: who holds the bus, whether a byte is outstanding, remaining CS-high cycles
    task automatic model_step();
        int o;
        if (RST) begin
            model_reset();
            return;
        end
        o = m_own;
        m_ab = '0;
        if (o >= 0) begin
            if (!m_busy) begin
                if (start[o]) m_busy = 1'b1;
                else if (!req[o]) begin
                    m_own = -1;
                    m_gap = CS;
                end else if (m_idle + 1 >= TO) begin
                    m_ab[o] = 1'b1;
                    m_own = -1;
                    m_gap = CS;
                end else m_idle++;
            end else if (SPI_Done_Sig) begin
                m_rd[o] = SPI_Rdata;
                m_busy = 1'b0;
                m_idle = 0;
            end
        end else if (m_gap > 0) m_gap--;
        else if (req != 2'b00) begin
            m_own = (req == 2'b11) ? int'(!m_last) : int'(req[1]);
            m_last = m_own[0];
            m_idle = 0;
        end
    endtask
    task automatic compare();
        logic g;
        logic o;
        g = m_own >= 0;
        o = m_own[0];
        check("grant", grant, {m_own == 1, m_own == 0});
        check("start", SPI_Start_Sig, g && start[o]);
        check("data", SPI_Data, g ? data[o] : 9'h1FF);
        check("done", done, {m_own == 1 && m_busy && SPI_Done_Sig, m_own == 0 && m_busy && SPI_Done_Sig});
        check("rdata0", C0_Rdata, m_rd[0]);
        check("rdata1", C1_Rdata, m_rd[1]);
        check("abort", abort, m_ab);
    endtask
    task automatic drive_engine();
        if (SPI_Done_Sig) begin
            SPI_Done_Sig = 1'b0;
            eng_busy = 1'b0;
        end else if (eng_busy) begin
            if (lat == 0) begin
                SPI_Done_Sig = 1'b1;
                SPI_Rdata = fix_en ? fix_val : 8'($urandom);
            end else lat--;
        end else if (s_start) begin
            eng_busy = 1'b1;
            lat = $urandom_range(0, 2);
        end else if (noise_en && $urandom_range(0, 15) == 0) begin
            SPI_Done_Sig = 1'b1;
            SPI_Rdata = 8'($urandom);
        end
    endtask
    task automatic drive_client(input int n);
        if (start[n]) begin
            if (sd[n]) begin
                start[n] = 1'b0;
                data[n] = 9'($urandom);
            end else if ($urandom_range(0, 7) == 0) req[n] = 1'b0;
        end else if (!req[n]) begin
            if ($urandom_range(0, 3) == 0) begin
                req[n] = 1'b1;
                left[n] = $urandom_range(0, 3);
            end
        end else if (grant[n]) begin
            if (left[n] == 0) req[n] = 1'b0;
            else if ($urandom_range(0, 1) == 1) begin
                start[n] = 1'b1;
                left[n]--;
            end
        end else data[n] = 9'($urandom);
    endtask
    task automatic tick();
        @(negedge CLK);
        compare();
        sd = done;
        s_start = SPI_Start_Sig;
        if (done[0]) dcnt0++;
        model_step();
        @(posedge CLK);
        #1;
        drive_engine();
        if (cli_en) begin
            drive_client(0);
            drive_client(1);
        end
    endtask
    task automatic send(input int n, input logic [8:0] d);
        int c;
        c = 0;
        data[n] = d;
        start[n] = 1'b1;
        do begin
            tick();
            c++;
        end while (!sd[n] && c < 20);
        check("send_done", sd[n], 1'b1);
        start[n] = 1'b0;
    endtask
    task automatic wait_grant(input int n, output int c);
        c = 0;
        while (!grant[n] && c < 40) begin
            tick();
            c++;
        end
    endtask
    initial begin
        RST = 1'b1;
        req = '0;
        start = '0;
        data = '0;
        SPI_Done_Sig = 1'b0;
        SPI_Rdata = '0;
        {cli_en, noise_en, eng_busy} = '0;
        fix_en = 1'b1;
        fix_val = 8'h5A;
        lat = 0;
        dcnt0 = 0;
        sd = '0;
        s_start = 1'b0;
        model_reset();
        repeat (2) tick();
        check("rst_data", SPI_Data, 9'h1FF);
        check("rst_start", SPI_Start_Sig, 1'b0);
        check("rst_grant", grant, 2'b00);
        check("rst_rdata", {C1_Rdata, C0_Rdata}, 16'h0000);
        RST = 1'b0;
        req = 2'b11;
        tick();
        check("arb_first", grant, 2'b01);
        send(0, 9'h084);
        send(0, 9'h0FF);
        send(0, 9'h000);
        send(0, 9'h005);
        check("c0_dones", dcnt0, 4);
        req[0] = 1'b0;
        tick();
        check("rel_grant0", grant[0], 1'b0);
        k = 1;
        while (!grant[1] && k < 20) begin
            if (k == 2) req[0] = 1'b1;
            tick();
            k++;
        end
        check("gap_to_c1", k, CS + 2);
        check("c0_waits", grant[0], 1'b0);
        fix_val = 8'hA5;
        send(1, 9'h03C);
        check("c1_rdata", C1_Rdata, 8'hA5);
        check("c0_rdata", C0_Rdata, 8'h5A);
        req[1] = 1'b0;
        tick();
        wait_grant(0, k);
        check("regrant_c0", k, CS + 1);
        req[1] = 1'b1;
        k = 0;
        while (!abort[0] && k < TO + 50) begin
            tick();
            k++;
        end
        check("abort_time", k, TO);
        check("abort_grant", grant[0], 1'b0);
        wait_grant(1, k);
        check("abort_to_c1", k, CS + 1);
        data[1] = 9'h1AA;
        start[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        k = 0;
        while (!sd[1] && k < 20) begin
            tick();
            k++;
        end
        start[1] = 1'b0;
        check("mid_done", sd[1], 1'b1);
        check("mid_hold", grant[1], 1'b1);
        tick();
        check("mid_gap", grant[1], 1'b0);
        wait_grant(0, k);
        check("mid_to_c0", k, CS + 1);
        data[0] = 9'h0C3;
        start[0] = 1'b1;
        tick();
        RST = 1'b1;
        #1;
        check("arst_start", SPI_Start_Sig, 1'b0);
        check("arst_data", SPI_Data, 9'h1FF);
        check("arst_grant", grant, 2'b00);
        model_reset();
        req = '0;
        start = '0;
        SPI_Done_Sig = 1'b0;
        eng_busy = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        req[1] = 1'b1;
        tick();
        check("post_rst", grant, 2'b10);
        req = '0;
        repeat (8) tick();
        fix_en = 1'b0;
        cli_en = 1'b1;
        noise_en = 1'b1;
        repeat (4000) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
